// File: rtl/fetch_bundle_queue_pkg.sv
// Shared front-end definitions: datapath widths and the bundle record
// that is carried from fetch-1 to fetch-2/decode.
package fetch_bundle_queue_pkg;

  localparam int SIZE_PC       = 32;
  localparam int INST_BUNDLE_W = 256;
  localparam int FETCH_WIDTH   = 4;

  typedef struct packed {
    logic [SIZE_PC-1:0]             pc;
    logic [INST_BUNDLE_W-1:0]       bundle;
    logic [FETCH_WIDTH-1:0]         btbHit;
    logic [FETCH_WIDTH-1:0]         prediction;
    logic [FETCH_WIDTH*SIZE_PC-1:0] targetAddr;
    logic [SIZE_PC-1:0]             addrRAS_CP;
  } fetch_bundle_t;

endpackage

// File: rtl/fetch_bundle_queue_ctrl.sv
// Pointer and occupancy control for the fetch bundle queue: qualifies
// push/pop, tracks head/tail/count and derives the full/empty flags.
module fbq_ctrl #(
  parameter int DEPTH = 4,
  parameter int PTR_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush_i,
  input  logic             valid_i,
  input  logic             ready_i,
  output logic             push_o,
  output logic             pop_o,
  output logic [PTR_W-1:0] headPtr_o,
  output logic [PTR_W-1:0] tailPtr_o,
  output logic [PTR_W:0]   count_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam logic [PTR_W:0]   FULL_COUNT = (PTR_W+1)'(DEPTH);
  localparam logic [PTR_W-1:0] PTR_ONE    = PTR_W'(1);
  localparam logic [PTR_W:0]   CNT_ONE    = (PTR_W+1)'(1);

  logic [PTR_W-1:0] headPtr_q, headPtr_d;
  logic [PTR_W-1:0] tailPtr_q, tailPtr_d;
  logic [PTR_W:0]   count_q, count_d;

  // Full is judged on the registered count alone, so a pop in the same
  // cycle never frees a slot for an incoming bundle.
  assign full_o  = (count_q == FULL_COUNT);
  assign empty_o = (count_q == '0);
  assign push_o  = valid_i & ~full_o & ~flush_i;
  assign pop_o   = ~empty_o & ready_i & ~flush_i;

  always_comb begin
    headPtr_d = headPtr_q;
    tailPtr_d = tailPtr_q;
    count_d   = count_q;
    if (flush_i) begin
      headPtr_d = '0;
      tailPtr_d = '0;
      count_d   = '0;
    end else begin
      if (push_o) tailPtr_d = tailPtr_q + PTR_ONE;
      if (pop_o)  headPtr_d = headPtr_q + PTR_ONE;
      if (push_o && !pop_o)      count_d = count_q + CNT_ONE;
      else if (pop_o && !push_o) count_d = count_q - CNT_ONE;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      headPtr_q <= '0;
      tailPtr_q <= '0;
      count_q   <= '0;
    end else begin
      headPtr_q <= headPtr_d;
      tailPtr_q <= tailPtr_d;
      count_q   <= count_d;
    end
  end

  assign headPtr_o = headPtr_q;
  assign tailPtr_o = tailPtr_q;
  assign count_o   = count_q;

endmodule

// File: rtl/fetch_bundle_queue.sv
// Decoupling FIFO between fetch-1 and fetch-2/decode; holds fetched bundles
// with their branch-prediction sideband and flushes on any redirect.
module fetch_bundle_queue #(
  parameter int SIZE_PC       = fetch_bundle_queue_pkg::SIZE_PC,
  parameter int INST_BUNDLE_W = fetch_bundle_queue_pkg::INST_BUNDLE_W,
  parameter int DEPTH         = 4,
  parameter int PTR_W         = $clog2(DEPTH)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     flush_i,
  input  logic                     valid_i,
  input  logic [SIZE_PC-1:0]       pc_i,
  input  logic [INST_BUNDLE_W-1:0] instructionBundle_i,
  input  logic [3:0]               btbHit_i,
  input  logic [3:0]               prediction_i,
  input  logic [4*SIZE_PC-1:0]     targetAddr_i,
  input  logic [SIZE_PC-1:0]       addrRAS_CP_i,
  output logic                     stall_o,
  input  logic                     ready_i,
  output logic                     valid_o,
  output logic [SIZE_PC-1:0]       pc_o,
  output logic [INST_BUNDLE_W-1:0] instructionBundle_o,
  output logic [3:0]               btbHit_o,
  output logic [3:0]               prediction_o,
  output logic [4*SIZE_PC-1:0]     targetAddr_o,
  output logic [SIZE_PC-1:0]       addrRAS_CP_o,
  output logic [PTR_W:0]           count_o
);

  import fetch_bundle_queue_pkg::*;

  logic             push;
  logic             pop;
  logic             full;
  logic             empty;
  logic [PTR_W-1:0] headPtr;
  logic [PTR_W-1:0] tailPtr;

  fetch_bundle_t entries_q [DEPTH];
  fetch_bundle_t wrEntry;
  fetch_bundle_t rdEntry;

  fbq_ctrl #(
    .DEPTH (DEPTH),
    .PTR_W (PTR_W)
  ) u_ctrl (
    .clk       (clk),
    .reset     (reset),
    .flush_i   (flush_i),
    .valid_i   (valid_i),
    .ready_i   (ready_i),
    .push_o    (push),
    .pop_o     (pop),
    .headPtr_o (headPtr),
    .tailPtr_o (tailPtr),
    .count_o   (count_o),
    .full_o    (full),
    .empty_o   (empty)
  );

  always_comb begin
    wrEntry            = '0;
    wrEntry.pc         = pc_i;
    wrEntry.bundle     = instructionBundle_i;
    wrEntry.btbHit     = btbHit_i;
    wrEntry.prediction = prediction_i;
    wrEntry.targetAddr = targetAddr_i;
    wrEntry.addrRAS_CP = addrRAS_CP_i;
  end

  // Payload is intentionally left unreset; valid_o gates its use.
  always_ff @(posedge clk) begin
    if (push) entries_q[tailPtr] <= wrEntry;
  end

  assign rdEntry = entries_q[headPtr];

  assign stall_o             = full;
  assign valid_o             = ~empty;
  assign pc_o                = rdEntry.pc;
  assign instructionBundle_o = rdEntry.bundle;
  assign btbHit_o            = rdEntry.btbHit;
  assign prediction_o        = rdEntry.prediction;
  assign targetAddr_o        = rdEntry.targetAddr;
  assign addrRAS_CP_o        = rdEntry.addrRAS_CP;

  logic unusedPop;
  assign unusedPop = pop;

endmodule

// File: tb/tb_fetch_bundle_queue.sv
// Directed self-checking bench for fetch_bundle_queue with hand-computed
// expected values for fill, drain, back-pressure, flush and pointer wrap.
module tb_fetch_bundle_queue;

  logic         clk;
  logic         reset;
  logic         flush_i;
  logic         valid_i;
  logic [31:0]  pc_i;
  logic [255:0] instructionBundle_i;
  logic [3:0]   btbHit_i;
  logic [3:0]   prediction_i;
  logic [127:0] targetAddr_i;
  logic [31:0]  addrRAS_CP_i;
  logic         stall_o;
  logic         ready_i;
  logic         valid_o;
  logic [31:0]  pc_o;
  logic [255:0] instructionBundle_o;
  logic [3:0]   btbHit_o;
  logic [3:0]   prediction_o;
  logic [127:0] targetAddr_o;
  logic [31:0]  addrRAS_CP_o;
  logic [2:0]   count_o;

  int checkCount = 0;
  int failCount  = 0;

  fetch_bundle_queue dut (
    .clk                 (clk),
    .reset               (reset),
    .flush_i             (flush_i),
    .valid_i             (valid_i),
    .pc_i                (pc_i),
    .instructionBundle_i (instructionBundle_i),
    .btbHit_i            (btbHit_i),
    .prediction_i        (prediction_i),
    .targetAddr_i        (targetAddr_i),
    .addrRAS_CP_i        (addrRAS_CP_i),
    .stall_o             (stall_o),
    .ready_i             (ready_i),
    .valid_o             (valid_o),
    .pc_o                (pc_o),
    .instructionBundle_o (instructionBundle_o),
    .btbHit_o            (btbHit_o),
    .prediction_o        (prediction_o),
    .targetAddr_o        (targetAddr_o),
    .addrRAS_CP_o        (addrRAS_CP_o),
    .count_o             (count_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Instruction words are derived from the PC so every bundle is distinct.
  function automatic logic [255:0] makeBundle(input logic [31:0] pc);
    logic [255:0] b;
    for (int i = 0; i < 8; i++) b[i*32 +: 32] = pc + 32'(i);
    return b;
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] actual,
                             input logic [63:0] expected);
    checkCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  // Sideband fields follow fixed rules from the PC unless a test overrides them.
  task automatic applyStimulus(input logic v, input logic [31:0] pc,
                               input logic rdy, input logic fl);
    valid_i             = v;
    pc_i                = pc;
    ready_i             = rdy;
    flush_i             = fl;
    instructionBundle_i = makeBundle(pc);
    btbHit_i            = pc[7:4];
    prediction_i        = ~pc[7:4];
    for (int k = 0; k < 4; k++) targetAddr_i[k*32 +: 32] = pc + 32'h1000 * 32'(k + 1);
    addrRAS_CP_i        = pc + 32'h4;
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic checkHeadPc(input string tag, input logic [31:0] pc);
    checkOutput({tag, "_valid"}, 64'(valid_o), 64'd1);
    checkOutput({tag, "_pc"}, 64'(pc_o), 64'(pc));
  endtask

  initial begin
    reset = 1'b1;
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0);
    #12;
    reset = 1'b0;

    // Reset then idle
    for (int i = 0; i < 5; i++) begin
      checkOutput("idle_valid", 64'(valid_o), 64'd0);
      checkOutput("idle_stall", 64'(stall_o), 64'd0);
      checkOutput("idle_count", 64'(count_o), 64'd0);
      tick();
    end

    // Fill with consumer stalled
    applyStimulus(1'b1, 32'h100, 1'b0, 1'b0); tick();
    checkOutput("fill_count1", 64'(count_o), 64'd1);
    checkHeadPc("fill_head1", 32'h100);
    applyStimulus(1'b1, 32'h120, 1'b0, 1'b0); tick();
    checkOutput("fill_count2", 64'(count_o), 64'd2);
    applyStimulus(1'b1, 32'h140, 1'b0, 1'b0); tick();
    checkOutput("fill_count3", 64'(count_o), 64'd3);
    checkOutput("fill_stall3", 64'(stall_o), 64'd0);
    applyStimulus(1'b1, 32'h160, 1'b0, 1'b0); tick();
    checkOutput("fill_count4", 64'(count_o), 64'd4);
    checkOutput("fill_stall4", 64'(stall_o), 64'd1);
    applyStimulus(1'b1, 32'h180, 1'b0, 1'b0); tick();
    checkOutput("full_hold_count", 64'(count_o), 64'd4);
    checkHeadPc("full_hold_head", 32'h100);

    // Full with simultaneous pop: pop happens, push refused
    applyStimulus(1'b1, 32'h180, 1'b1, 1'b0); tick();
    checkOutput("fullpop_count", 64'(count_o), 64'd3);
    checkOutput("fullpop_stall", 64'(stall_o), 64'd0);
    checkHeadPc("fullpop_head", 32'h120);
    tick();
    checkOutput("pushpop_count", 64'(count_o), 64'd3);
    checkHeadPc("pushpop_head", 32'h140);
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b0); tick();
    checkOutput("drain_count2", 64'(count_o), 64'd2);
    checkHeadPc("drain_head2", 32'h160);
    tick();
    checkOutput("drain_count1", 64'(count_o), 64'd1);
    checkHeadPc("drain_head1", 32'h180);
    tick();
    checkOutput("drain_count0", 64'(count_o), 64'd0);
    checkOutput("drain_valid0", 64'(valid_o), 64'd0);

    // Empty queue, single bundle with explicit sideband, consumer ready
    applyStimulus(1'b1, 32'h200, 1'b1, 1'b0);
    btbHit_i = 4'b0010;
    targetAddr_i[63:32] = 32'h300;
    checkOutput("nofall_valid", 64'(valid_o), 64'd0);
    tick();
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b0);
    checkHeadPc("single", 32'h200);
    checkOutput("single_count", 64'(count_o), 64'd1);
    checkOutput("single_btb", 64'(btbHit_o), 64'h2);
    checkOutput("single_pred", 64'(prediction_o), 64'hF);
    checkOutput("single_tgt0", 64'(targetAddr_o[31:0]), 64'h1200);
    checkOutput("single_tgt1", 64'(targetAddr_o[63:32]), 64'h300);
    checkOutput("single_tgt3", 64'(targetAddr_o[127:96]), 64'h4200);
    checkOutput("single_ras", 64'(addrRAS_CP_o), 64'h204);
    checkOutput("single_bndlo", instructionBundle_o[63:0], 64'h0000_0201_0000_0200);
    checkOutput("single_bndhi", instructionBundle_o[255:192], 64'h0000_0207_0000_0206);
    tick();
    checkOutput("single_count0", 64'(count_o), 64'd0);
    checkOutput("single_valid0", 64'(valid_o), 64'd0);

    // Flush has priority over push and pop
    applyStimulus(1'b1, 32'h400, 1'b0, 1'b0); tick();
    applyStimulus(1'b1, 32'h420, 1'b0, 1'b0); tick();
    applyStimulus(1'b1, 32'h440, 1'b0, 1'b0); tick();
    checkOutput("preflush_count", 64'(count_o), 64'd3);
    applyStimulus(1'b1, 32'h460, 1'b1, 1'b1); tick();
    checkOutput("flush_count", 64'(count_o), 64'd0);
    checkOutput("flush_valid", 64'(valid_o), 64'd0);
    checkOutput("flush_stall", 64'(stall_o), 64'd0);
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b0); tick();
    checkOutput("postflush_valid", 64'(valid_o), 64'd0);
    applyStimulus(1'b1, 32'h480, 1'b0, 1'b0); tick();
    checkHeadPc("postflush_head", 32'h480);
    checkOutput("postflush_count", 64'(count_o), 64'd1);
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b0); tick();
    checkOutput("postflush_drain", 64'(count_o), 64'd0);

    // Interleaved push/pop across pointer wrap
    for (int i = 0; i < 10; i++) begin
      applyStimulus(1'b1, 32'h1000 + 32'(i) * 32'h20, 1'b1, 1'b0);
      if (i > 0) checkHeadPc("wrap_head", 32'h1000 + 32'(i - 1) * 32'h20);
      tick();
      checkOutput("wrap_count", 64'(count_o), 64'd1);
    end
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b0);
    checkHeadPc("wrap_last", 32'h1120);
    tick();
    checkOutput("wrap_count0", 64'(count_o), 64'd0);

    // Asynchronous reset between clock edges
    applyStimulus(1'b1, 32'h500, 1'b0, 1'b0); tick();
    applyStimulus(1'b1, 32'h520, 1'b0, 1'b0); tick();
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0);
    checkOutput("prereset_count", 64'(count_o), 64'd2);
    #2;
    reset = 1'b1;
    #1;
    checkOutput("areset_count", 64'(count_o), 64'd0);
    checkOutput("areset_valid", 64'(valid_o), 64'd0);
    reset = 1'b0;
    tick();
    checkOutput("areset_idle", 64'(count_o), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
    $finish;
  end

endmodule
